// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the simple RISC core.
// Holds the opcode encoding, the instruction-cycle phase encoding and the
// ALUOP membership helper used by the controller, decoder and ALU.
package risc_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PHASE_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read a memory operand and write the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_phase_counter.sv
// phase_counter: 3-bit wrapping instruction-phase counter.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears count to 0
//   en          count enable
//   halt_freeze synchronous freeze; count advances only on en & ~halt_freeze
//   count       current phase, wraps 7 -> 0
module phase_counter
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               halt_freeze,
  output logic [PHASE_W-1:0] count
);

  logic [PHASE_W-1:0] count_q;
  logic [PHASE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && !halt_freeze) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/risc_controller.sv
// risc_controller: fetch/execute sequencer for the simple RISC core.
// Runs the 8-phase instruction cycle and decodes every control strobe from
// the registered phase, the IR opcode and the accumulator zero flag.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          run enable; phase advances only while high
//   opcode      IR opcode, stable from phase 3 onward
//   zero        accumulator == 0, consulted only in phase 6
//   phase       current phase 0..7
//   sel, rd, data_e                    level outputs (not gated by en)
//   ld_ir, inc_pc, ld_pc, ld_ac, wr    strobes, gated by en & ~halted
//   halt        processor halted
module risc_controller
  import risc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [PHASE_W-1:0]  phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt
);

  logic [PHASE_W-1:0] phase_cnt;
  phase_e             phase_cur;
  opcode_e            op;
  logic               aluop;
  logic               halted_q;
  logic               halted_d;
  logic               halt_now;
  logic               strobe_en;

  // Raw strobes before en/halted gating.
  logic ld_ir_raw, inc_pc_raw, ld_pc_raw, ld_ac_raw, wr_raw;

  assign phase_cur = phase_e'(phase_cnt);
  assign op        = opcode_e'(opcode);
  assign aluop     = is_aluop(op);

  // HLT in OP_ADDR already freezes the counter on the edge that sets
  // halted_q, so the phase never leaves 4 once a halt is taken.
  assign halt_now = halted_q || ((phase_cur == OP_ADDR) && (op == HLT));

  phase_counter u_phase_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .halt_freeze (halt_now),
    .count       (phase_cnt)
  );

  always_comb begin
    halted_d = halted_q;
    if (en && (phase_cur == OP_ADDR) && (op == HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel        = 1'b0;
    rd         = 1'b0;
    data_e     = 1'b0;
    ld_ir_raw  = 1'b0;
    inc_pc_raw = 1'b0;
    ld_pc_raw  = 1'b0;
    ld_ac_raw  = 1'b0;
    wr_raw     = 1'b0;
    unique case (phase_cur)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel       = 1'b1;
        rd        = 1'b1;
        ld_ir_raw = 1'b1;
      end
      OP_ADDR: begin
        inc_pc_raw = 1'b1;
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd         = aluop;
        inc_pc_raw = (op == SKZ) && zero;
        ld_pc_raw  = (op == JMP);
        data_e     = (op == STO);
      end
      STORE: begin
        rd        = aluop;
        ld_ac_raw = aluop;
        ld_pc_raw = (op == JMP);
        wr_raw    = (op == STO);
        data_e    = (op == STO);
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

  assign strobe_en = en && !halted_q;

  assign phase  = phase_cnt;
  assign ld_ir  = ld_ir_raw  && strobe_en;
  assign inc_pc = inc_pc_raw && strobe_en;
  assign ld_pc  = ld_pc_raw  && strobe_en;
  assign ld_ac  = ld_ac_raw  && strobe_en;
  assign wr     = wr_raw     && strobe_en;
  assign halt   = halt_now;

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed and randomized bench for risc_controller,
// checked against a phase/halt reference model and per-instruction strobe
// counts.
module tb_risc_controller;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_phase  = 0;
  bit m_halted = 0;
  int n_inc = 0, n_ldir = 0, n_ldpc = 0, n_wr = 0, n_ldac = 0;
  bit skz_taken = 0;
  int halted_cycles = 0;

  risc_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_alu(input int op);
    return op == 2 || op == 3 || op == 4 || op == 5;
  endfunction

  // Expected {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  // straight from the phase table.
  function automatic logic [11:0] expected_outputs();
    int  ph = m_phase;
    int  op = int'(opcode);
    bit  go = en && !m_halted;
    bit  e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
    e_sel  = ph <= 3;
    e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && is_alu(op));
    e_ldir = go && (ph == 2 || ph == 3);
    e_inc  = go && (ph == 4 || (ph == 6 && op == 1 && zero));
    e_ldpc = go && (ph == 6 || ph == 7) && op == 7;
    e_ldac = go && ph == 7 && is_alu(op);
    e_wr   = go && ph == 7 && op == 6;
    e_de   = (ph == 6 || ph == 7) && op == 6;
    e_halt = m_halted || (ph == 4 && op == 0);
    return {3'(ph), e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_halted = 0; halted_cycles = 0;
    n_inc = 0; n_ldir = 0; n_ldpc = 0; n_wr = 0; n_ldac = 0; skz_taken = 0;
  endtask

  // Whole-instruction strobe tallies, checked as phase 7 retires.
  task automatic instruction_done();
    int op = int'(opcode);
    check_eq("ld_ir_count",  n_ldir, 2);
    check_eq("inc_pc_count", n_inc, 1 + int'(skz_taken));
    check_eq("ld_pc_count",  n_ldpc, (op == 7) ? 2 : 0);
    check_eq("wr_count",     n_wr, (op == 6) ? 1 : 0);
    check_eq("ld_ac_count",  n_ldac, is_alu(op) ? 1 : 0);
    n_inc = 0; n_ldir = 0; n_ldpc = 0; n_wr = 0; n_ldac = 0; skz_taken = 0;
  endtask

  task automatic model_advance();
    if (en && !m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) begin
        m_halted = 1;
      end else if (m_phase == 7) begin
        instruction_done();
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  // One clock: check at negedge, step the model at posedge, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    check_eq("outputs", {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
             expected_outputs());
    check_eq("inc_ld_pc_excl", 32'(inc_pc & ld_pc), 0);
    if (rst_n) begin
      n_inc  += int'(inc_pc);
      n_ldir += int'(ld_ir);
      n_ldpc += int'(ld_pc);
      n_wr   += int'(wr);
      n_ldac += int'(ld_ac);
      if (m_phase == 6 && en && !m_halted && opcode == 3'd1 && zero) skz_taken = 1;
    end
    @(posedge clk);
    if (rst_n) model_advance();
    halted_cycles = m_halted ? halted_cycles + 1 : 0;
    #1;
  endtask

  // Asynchronous reset pulse taken mid-cycle (caller is at posedge+1).
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_phase", 32'(phase), 0);
    check_eq("rst_async_halt", 32'(halt), 0);
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; en = 1'b0; opcode = 3'd0; zero = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1; en = 1'b1; opcode = 3'd2;

    // Directed instruction pattern: ADD, STO, SKZ taken, SKZ not taken, JMP
    begin
      int ops[5]   = '{2, 6, 1, 1, 7};
      bit zeros[5] = '{0, 0, 1, 0, 1};
      for (int i = 0; i < 5; i++) begin
        opcode = 3'(ops[i]);
        zero   = zeros[i];
        repeat (8) cycle();
      end
    end

    // Stall in phase 4: phase holds, inc_pc counted once per instruction
    opcode = 3'd2; zero = 1'b0;
    repeat (4) cycle();
    check_eq("stall_at_phase4", 32'(m_phase), 4);
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (4) cycle();

    // HLT with en low in phase 4 does not halt until an enabled clock
    opcode = 3'd0;
    repeat (4) cycle();
    en = 1'b0;
    repeat (3) cycle();
    check_eq("hlt_not_latched_while_stalled", 32'(m_halted), 0);
    en = 1'b1;
    repeat (24) cycle();
    check_eq("halt_held", 32'(halt), 1);
    check_eq("halt_phase", 32'(phase), 4);
    do_reset();
    check_eq("halt_cleared", 32'(halt), 0);

    // Reset asserted in phase 7 of STO drops wr/data_e without a clock
    opcode = 3'd6;
    repeat (7) cycle();
    #2;
    check_eq("sto_wr_before_rst", 32'(wr), 1);
    check_eq("sto_de_before_rst", 32'(data_e), 1);
    rst_n = 1'b0;
    #1;
    check_eq("sto_wr_async", 32'(wr), 0);
    check_eq("sto_de_async", 32'(data_e), 0);
    check_eq("sto_phase_async", 32'(phase), 0);
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Randomized run
    repeat (1500) begin
      en   = ($urandom_range(0, 7) != 0);
      zero = 1'($urandom);
      if (m_phase == 0) begin
        r = int'($urandom_range(0, 15));
        opcode = (r == 0) ? 3'd0 : 3'((r % 7) + 1);
      end
      if (halted_cycles > 20 || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
